// File: rtl/mul_iter_nb.sv
// Iterative unsigned WIDTH x WIDTH multiplier / squarer built around one LIMB x LIMB multiplier.
// Partial products are walked limb by limb and summed into a 2*WIDTH accumulator.

module mul_64b_wrapper (
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic [127:0] p
);
  assign p = 128'(a) * 128'(b);
endmodule

module mul_iter_nb #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P
);

  localparam int N  = WIDTH / LIMB;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(2 * WIDTH) + 1;
  localparam int AW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                mode_q, mode_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [IW-1:0]       i_q, i_d;
  logic [IW-1:0]       j_q, j_d;
  logic [AW-1:0]       p_q, p_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [LIMB-1:0]     a_limb_s;
  logic [LIMB-1:0]     b_limb_s;
  logic [2*LIMB-1:0]   pp_s;
  logic [2*LIMB:0]     term_s;
  logic [AW:0]         term_sh_s;
  logic [SW-1:0]       shamt_s;
  logic [AW-1:0]       acc_next_s;
  logic                accept_s;
  logic                last_j_s;
  logic                last_term_s;

  assign accept_s    = in_valid && in_ready_q;
  assign last_j_s    = (j_q == LAST_IDX);
  assign last_term_s = (i_q == LAST_IDX) && (j_q == LAST_IDX);

  generate
    if (LIMB == 64) begin : g_wrap
      mul_64b_wrapper u_limb_mul (
        .a (a_limb_s),
        .b (b_limb_s),
        .p (pp_s)
      );
    end else begin : g_infer
      assign pp_s = (2*LIMB)'(a_limb_s) * (2*LIMB)'(b_limb_s);
    end
  endgenerate

  // Off-diagonal square terms appear twice in the full product, so they are doubled here.
  always_comb begin
    a_limb_s = a_q[i_q*LIMB +: LIMB];
    b_limb_s = b_q[j_q*LIMB +: LIMB];
    if (mode_q && (j_q != i_q)) begin
      term_s = {pp_s, 1'b0};
    end else begin
      term_s = {1'b0, pp_s};
    end
    shamt_s    = (SW'(i_q) + SW'(j_q)) * SW'(LIMB);
    term_sh_s  = (AW+1)'(term_s) << shamt_s;
    acc_next_s = acc_q + term_sh_s[AW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (last_term_s) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are decoded from the next state so they leave the block registered.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    acc_d  = acc_q;
    i_d    = i_q;
    j_d    = j_q;
    p_d    = p_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d    = A;
          b_d    = mode ? A : B;
          mode_d = mode;
          acc_d  = {AW{1'b0}};
          i_d    = {IW{1'b0}};
          j_d    = {IW{1'b0}};
        end else begin
          acc_d = acc_q;
        end
      end
      CALC: begin
        acc_d = acc_next_s;
        if (last_term_s) begin
          p_d = acc_next_s;
          i_d = {IW{1'b0}};
          j_d = {IW{1'b0}};
        end else if (last_j_s) begin
          i_d = i_q + IW'(1);
          j_d = mode_q ? (i_q + IW'(1)) : {IW{1'b0}};
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      DONE: begin
        p_d = p_q;
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      mode_q      <= 1'b0;
      acc_q       <= {AW{1'b0}};
      i_q         <= {IW{1'b0}};
      j_q         <= {IW{1'b0}};
      p_q         <= {AW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign P         = p_q;

endmodule

// File: tb/tb_mul_iter_nb.sv
// Directed and random checks of mul_iter_nb at 256/64 (main), 128/32 and 64/64.

module tb_mul_iter_nb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         iv0, ir0, md0, ov0, or0;
  logic [255:0] a0, b0;
  logic [511:0] p0;
  logic         iv1, ir1, md1, ov1, or1;
  logic [127:0] a1, b1;
  logic [255:0] p1;
  logic         iv2, ir2, md2, ov2, or2;
  logic [63:0]  a2, b2;
  logic [127:0] p2;

  int nchecks = 0;
  int nerr    = 0;

  logic [511:0] p, expp, ones_sq;
  logic [255:0] ra, rb, rc, rd, ones;
  int           lat, nl, explat;

  mul_iter_nb #(.WIDTH(256), .LIMB(64)) dut (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .mode(md0), .A(a0), .B(b0),
    .out_valid(ov0), .out_ready(or0), .P(p0));

  mul_iter_nb #(.WIDTH(128), .LIMB(32)) dut128 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .mode(md1), .A(a1), .B(b1),
    .out_valid(ov1), .out_ready(or1), .P(p1));

  mul_iter_nb #(.WIDTH(64), .LIMB(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .mode(md2), .A(a2), .B(b2),
    .out_valid(ov2), .out_ready(or2), .P(p2));

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [511:0] model(input int k, input logic m,
                                         input logic [255:0] a, input logic [255:0] b);
    logic [255:0] ma, mb;
    case (k)
      0:       begin ma = a;                 mb = b;                 end
      1:       begin ma = {128'd0, a[127:0]}; mb = {128'd0, b[127:0]}; end
      default: begin ma = {192'd0, a[63:0]};  mb = {192'd0, b[63:0]};  end
    endcase
    if (m) mb = ma;
    return {256'd0, ma} * {256'd0, mb};
  endfunction

  function automatic logic get_ov(input int k);
    case (k)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic [511:0] get_p(input int k);
    case (k)
      0:       return p0;
      1:       return {256'd0, p1};
      default: return {384'd0, p2};
    endcase
  endfunction

  task automatic drive(input int k, input logic v, input logic m,
                       input logic [255:0] a, input logic [255:0] b);
    case (k)
      0:       begin iv0 = v; md0 = m; a0 = a;        b0 = b;        end
      1:       begin iv1 = v; md1 = m; a1 = a[127:0]; b1 = b[127:0]; end
      default: begin iv2 = v; md2 = m; a2 = a[63:0];  b2 = b[63:0];  end
    endcase
  endtask

  task automatic set_or(input int k, input logic v);
    case (k)
      0:       or0 = v;
      1:       or1 = v;
      default: or2 = v;
    endcase
  endtask

  // Called #1 after an edge with the instance idle; lat counts the accept cycle as cycle 0.
  task automatic run_op(input int k, input logic m, input logic [255:0] a, input logic [255:0] b,
                        input logic hs, output logic [511:0] res, output int lt);
    int cnt;
    drive(k, 1'b1, m, a, b);
    @(posedge clk); #1;
    drive(k, 1'b0, ~m, ~a, ~b);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!get_ov(k) && cnt < 200);
    if (get_ov(k) !== 1'b1) chk("out_valid_timeout", {511'd0, get_ov(k)}, 512'd1);
    res = get_p(k);
    lt  = cnt + 1;
    if (hs) begin
      set_or(k, 1'b1);
      @(posedge clk); #1;
      set_or(k, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 256'd0, 256'd0);
    drive(1, 1'b0, 1'b0, 256'd0, 256'd0);
    drive(2, 1'b0, 1'b0, 256'd0, 256'd0);
    or0 = 1'b0; or1 = 1'b0; or2 = 1'b0;
    ones    = {256{1'b1}};
    ones_sq = {{63{4'hF}}, 4'hE, {63{4'h0}}, 4'h1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {511'd0, ir0}, 512'd1);
    chk("rst_out_valid", {511'd0, ov0}, 512'd0);
    chk("rst_p",         p0,            512'd0);
    chk("rst_in_ready_128", {511'd0, ir1}, 512'd1);
    chk("rst_in_ready_64",  {511'd0, ir2}, 512'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    or0 = 1'b1;
    @(posedge clk); #1;
    or0 = 1'b0;
    chk("idle_out_ready_ov", {511'd0, ov0}, 512'd0);
    chk("idle_out_ready_ir", {511'd0, ir0}, 512'd1);

    run_op(0, 1'b0, 256'd0, 256'd0, 1'b1, p, lat);
    chk("mul_zero_p",   p,          512'd0);
    chk("mul_zero_lat", 512'(lat),  512'd17);

    run_op(0, 1'b0, ones, ones, 1'b1, p, lat);
    chk("mul_ones_p",   p,          ones_sq);
    chk("mul_ones_lat", 512'(lat),  512'd17);

    run_op(0, 1'b1, ones, 256'd0, 1'b1, p, lat);
    chk("sq_ones_p",    p,          ones_sq);
    chk("sq_ones_lat",  512'(lat),  512'd11);

    ra = rand256();
    rb = rand256();
    run_op(0, 1'b1, ra, rb, 1'b1, p, lat);
    chk("sq_rand_p",    p,          model(0, 1'b1, ra, rb));
    chk("sq_rand_lat",  512'(lat),  512'd11);

    run_op(0, 1'b0, {1'b1, 255'd0}, 256'd2, 1'b1, p, lat);
    chk("mul_pow2_p",   p,          {255'd0, 1'b1, 256'd0});

    run_op(0, 1'b0, 256'd3, 256'd5, 1'b1, p, lat);
    chk("mul_3x5_p",    p,          512'd15);

    ra = rand256();
    rb = rand256();
    rc = rand256();
    rd = rand256();
    expp = model(0, 1'b0, ra, rb);
    run_op(0, 1'b0, ra, rb, 1'b0, p, lat);
    chk("bp_first_p", p, expp);
    for (int c = 0; c < 20; c++) begin
      drive(0, ((c % 2) == 0) ? 1'b1 : 1'b0, 1'b1, rc, rd);
      @(posedge clk); #1;
      chk("bp_hold_p",  p0,            expp);
      chk("bp_hold_ir", {511'd0, ir0}, 512'd0);
      chk("bp_hold_ov", {511'd0, ov0}, 512'd1);
    end
    drive(0, 1'b0, 1'b0, 256'd0, 256'd0);
    or0 = 1'b1;
    @(posedge clk); #1;
    or0 = 1'b0;
    chk("bp_release_ov", {511'd0, ov0}, 512'd0);
    chk("bp_release_ir", {511'd0, ir0}, 512'd1);
    chk("bp_release_p",  p0,            expp);
    @(posedge clk); #1;
    chk("bp_not_queued_ir", {511'd0, ir0}, 512'd1);
    run_op(0, 1'b0, rc, rd, 1'b1, p, lat);
    chk("bp_second_p", p, model(0, 1'b0, rc, rd));

    drive(0, 1'b1, 1'b0, 256'd7, 256'd9);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 256'd0, 256'd0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ov", {511'd0, ov0}, 512'd0);
    chk("midrst_p",  p0,            512'd0);
    chk("midrst_ir", {511'd0, ir0}, 512'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_ov", {511'd0, ov0}, 512'd0);
    run_op(0, 1'b0, 256'd3, 256'd5, 1'b1, p, lat);
    chk("postrst_p",   p,         512'd15);
    chk("postrst_lat", 512'(lat), 512'd17);

    for (int k = 0; k < 3; k++) begin
      nl = (k == 2) ? 1 : 4;
      for (int m = 0; m < 2; m++) begin
        explat = (m == 1) ? (nl * (nl + 1) / 2 + 1) : (nl * nl + 1);
        for (int n = 0; n < 100; n++) begin
          ra = rand256();
          rb = rand256();
          if (n == 0) begin
            ra = ones;
            rb = ones;
          end
          run_op(k, (m == 1), ra, rb, 1'b1, p, lat);
          chk("sweep_p",   p,         model(k, (m == 1), ra, rb));
          chk("sweep_lat", 512'(lat), 512'(explat));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
